dcache_miss_queue: RTL and testbench



---
 rtl/dcache_miss_queue.sv | 126 ++++++++++++
 tb/tb_dcache_miss_queue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_queue.sv
// Non-blocking dcache miss handler: an in-order miss FIFO toward Dmem plus a tag
// table that turns returning fills into cache line writes and CDB load broadcasts.
module dcache_miss_queue #(
  parameter int QUEUE_DEPTH    = 8,
  parameter int QUEUE_IDX_BITS = 3,
  parameter int MEM_TAGS       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_data,
  input  logic [6:0]  req_pr,
  input  logic [4:0]  req_ar,
  output logic        req_ready,
  output logic [1:0]  proc2Dmem_command,
  output logic [63:0] proc2Dmem_addr,
  output logic [63:0] proc2Dmem_data,
  input  logic [3:0]  Dmem2proc_response,
  input  logic [63:0] Dmem2proc_data,
  input  logic [3:0]  Dmem2proc_tag,
  output logic        fill_en,
  output logic [6:0]  fill_idx,
  output logic [21:0] fill_tag,
  output logic [63:0] fill_data,
  output logic        cdb_load_en,
  output logic [6:0]  cdb_pr,
  output logic [4:0]  cdb_ar,
  output logic [63:0] cdb_data,
  output logic        idle
);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [QUEUE_IDX_BITS:0] FULL = (QUEUE_IDX_BITS+1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic        is_store;
    logic [63:0] addr;
    logic [63:0] data;
    logic [6:0]  pr;
    logic [4:0]  ar;
  } mq_entry_t;

  typedef struct packed {
    logic        occ;
    logic [6:0]  idx;
    logic [21:0] tag;
    logic [6:0]  pr;
    logic [4:0]  ar;
  } tag_entry_t;

  mq_entry_t                 fifo [QUEUE_DEPTH];
  tag_entry_t                tbl  [MEM_TAGS];
  logic [QUEUE_IDX_BITS-1:0] head, tail;
  logic [QUEUE_IDX_BITS:0]   count;
  mq_entry_t                 hd;
  tag_entry_t                fe;
  logic                      empty, push, pop, fill_hit, rsp_busy;
  logic [MEM_TAGS-1:0]       occ_vec;

  always_comb begin
    hd       = fifo[head];
    fe       = tbl[Dmem2proc_tag];
    empty    = (count == '0);
    req_ready = (count != FULL);
    push     = req_valid && req_ready;
    fill_hit = (Dmem2proc_tag != '0) && fe.occ;
    // A tag being retired this very cycle may be handed out again immediately.
    rsp_busy = tbl[Dmem2proc_response].occ &&
               !(fill_hit && (Dmem2proc_tag == Dmem2proc_response));
    pop      = !empty && (Dmem2proc_response != '0) && (hd.is_store || !rsp_busy);
    for (int i = 0; i < MEM_TAGS; i++) occ_vec[i] = tbl[i].occ;
    idle     = empty && (occ_vec == '0);
  end

  always_comb begin
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    if (!empty) begin
      proc2Dmem_command = hd.is_store ? BUS_STORE : BUS_LOAD;
      proc2Dmem_addr    = hd.addr;
      proc2Dmem_data    = hd.data;
    end
  end

  always_comb begin
    fill_en     = fill_hit;
    cdb_load_en = fill_hit;
    fill_idx    = fill_hit ? fe.idx : '0;
    fill_tag    = fill_hit ? fe.tag : '0;
    fill_data   = fill_hit ? Dmem2proc_data : '0;
    cdb_pr      = fill_hit ? fe.pr : '0;
    cdb_ar      = fill_hit ? fe.ar : '0;
    cdb_data    = fill_hit ? Dmem2proc_data : '0;
  end

  always_ff @(posedge clock) begin
    if (push) fifo[tail] <= '{is_store: req_is_store, addr: req_addr, data: req_data,
                              pr: req_pr, ar: req_ar};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < MEM_TAGS; i++) tbl[i].occ <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fill_hit) tbl[Dmem2proc_tag].occ <= 1'b0;
      // Placed after the clear so a same-cycle reallocation of the tag wins.
      if (pop && !hd.is_store)
        tbl[Dmem2proc_response] <= '{occ: 1'b1, idx: hd.addr[9:3], tag: hd.addr[31:10],
                                     pr: hd.pr, ar: hd.ar};
    end
  end
endmodule

// File: tb/tb_dcache_miss_queue.sv
// Directed bench for dcache_miss_queue: a queue/array model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_dcache_miss_queue;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_is_store;
  logic [63:0] req_addr, req_data;
  logic [6:0]  req_pr;
  logic [4:0]  req_ar;
  logic        req_ready;
  logic [1:0]  proc2Dmem_command;
  logic [63:0] proc2Dmem_addr, proc2Dmem_data;
  logic [3:0]  Dmem2proc_response;
  logic [63:0] Dmem2proc_data;
  logic [3:0]  Dmem2proc_tag;
  logic        fill_en;
  logic [6:0]  fill_idx;
  logic [21:0] fill_tag;
  logic [63:0] fill_data;
  logic        cdb_load_en;
  logic [6:0]  cdb_pr;
  logic [4:0]  cdb_ar;
  logic [63:0] cdb_data;
  logic        idle;

  dcache_miss_queue dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_data(req_data), .req_pr(req_pr), .req_ar(req_ar),
    .req_ready(req_ready), .proc2Dmem_command(proc2Dmem_command),
    .proc2Dmem_addr(proc2Dmem_addr), .proc2Dmem_data(proc2Dmem_data),
    .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
    .Dmem2proc_tag(Dmem2proc_tag), .fill_en(fill_en), .fill_idx(fill_idx),
    .fill_tag(fill_tag), .fill_data(fill_data), .cdb_load_en(cdb_load_en),
    .cdb_pr(cdb_pr), .cdb_ar(cdb_ar), .cdb_data(cdb_data), .idle(idle)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          st;
    logic [63:0] addr;
    logic [63:0] data;
    logic [6:0]  pr;
    logic [4:0]  ar;
  } req_t;

  req_t        mq[$];
  bit          m_occ  [16];
  logic [63:0] m_addr [16];
  logic [6:0]  m_pr   [16];
  logic [4:0]  m_ar   [16];
  bit          model_valid = 0;

  always @(posedge clock) begin
    bit rdy, fill_ok, acc;
    int t, r;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < 16; i++) m_occ[i] = 0;
      model_valid = 1;
    end else if (model_valid) begin
      t = Dmem2proc_tag;
      r = Dmem2proc_response;
      rdy = mq.size() < 8;
      fill_ok = (t != 0) && m_occ[t];
      acc = (mq.size() > 0) && (r != 0) &&
            (mq[0].st || !m_occ[r] || (fill_ok && t == r));
      if (fill_ok) m_occ[t] = 0;
      if (acc) begin
        if (!mq[0].st) begin
          m_occ[r] = 1; m_addr[r] = mq[0].addr; m_pr[r] = mq[0].pr; m_ar[r] = mq[0].ar;
        end
        void'(mq.pop_front());
      end
      if (req_valid && rdy)
        mq.push_back('{st: req_is_store, addr: req_addr, data: req_data, pr: req_pr, ar: req_ar});
    end
  end

  always @(negedge clock) begin
    int t;
    bit hit, any;
    if (model_valid) begin
      t = Dmem2proc_tag;
      hit = (t != 0) && m_occ[t];
      any = 0;
      for (int i = 0; i < 16; i++) any |= m_occ[i];
      check("m_ready", req_ready, mq.size() < 8);
      check("m_idle", idle, (mq.size() == 0) && !any);
      check("m_cmd", proc2Dmem_command, mq.size() == 0 ? 0 : (mq[0].st ? 2 : 1));
      check("m_addr", proc2Dmem_addr, mq.size() == 0 ? 64'd0 : mq[0].addr);
      check("m_data", proc2Dmem_data, mq.size() == 0 ? 64'd0 : mq[0].data);
      check("m_fill_en", fill_en, hit);
      check("m_cdb_en", cdb_load_en, hit);
      check("m_fill_idx", fill_idx, hit ? (m_addr[t] >> 3) % 128 : 0);
      check("m_fill_tag", fill_tag, hit ? (m_addr[t] >> 10) % (64'd1 << 22) : 0);
      check("m_fill_data", fill_data, hit ? Dmem2proc_data : 64'd0);
      check("m_cdb_data", cdb_data, hit ? Dmem2proc_data : 64'd0);
      check("m_cdb_pr", cdb_pr, hit ? m_pr[t] : 0);
      check("m_cdb_ar", cdb_ar, hit ? m_ar[t] : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic zero_in();
    req_valid = 0; req_is_store = 0; req_addr = 0; req_data = 0; req_pr = 0; req_ar = 0;
    Dmem2proc_response = 0; Dmem2proc_data = 0; Dmem2proc_tag = 0;
  endtask

  task automatic set_req(input bit st, input logic [63:0] a, input logic [63:0] d,
                         input logic [6:0] pr, input logic [4:0] ar);
    req_valid = 1; req_is_store = st; req_addr = a; req_data = d; req_pr = pr; req_ar = ar;
  endtask

  initial begin
    zero_in();
    reset = 1;
    cyc(); cyc();
    at_neg();
    check("rst_ready", req_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_cmd", proc2Dmem_command, 0);
    check("rst_fill_en", fill_en, 0);
    check("rst_cdb_data", cdb_data, 0);
    cyc();
    reset = 0;

    // 1: single load miss, fill later
    set_req(0, 64'h1238, 0, 9, 3);
    cyc();
    zero_in();
    at_neg();
    check("t1_cmd", proc2Dmem_command, 1);
    check("t1_addr", proc2Dmem_addr, 64'h1238);
    cyc();
    Dmem2proc_response = 5;
    cyc();
    zero_in();
    at_neg();
    check("t1_popped", proc2Dmem_command, 0);
    check("t1_busy", idle, 0);
    cyc(); cyc();
    Dmem2proc_tag = 5; Dmem2proc_data = 64'hDEAD;
    at_neg();
    check("t1_fill_en", fill_en, 1);
    check("t1_fill_idx", fill_idx, 7'h47);
    check("t1_fill_tag", fill_tag, 22'h4);
    check("t1_pr", cdb_pr, 9);
    check("t1_ar", cdb_ar, 3);
    check("t1_data", cdb_data, 64'hDEAD);
    cyc();
    zero_in();
    at_neg();
    check("t1_idle", idle, 1);

    // 2: store held by three rejects, then accepted with tag 2
    cyc();
    set_req(1, 64'h40, 64'h55, 0, 0);
    cyc();
    zero_in();
    for (int k = 0; k < 4; k++) begin
      Dmem2proc_response = (k == 3) ? 4'd2 : 4'd0;
      at_neg();
      check("t2_cmd", proc2Dmem_command, 2);
      check("t2_addr", proc2Dmem_addr, 64'h40);
      check("t2_data", proc2Dmem_data, 64'h55);
      cyc();
    end
    zero_in();
    at_neg();
    check("t2_popped", proc2Dmem_command, 0);
    cyc();
    Dmem2proc_tag = 2; Dmem2proc_data = 64'h77;
    at_neg();
    check("t2_nofill", fill_en, 0);
    check("t2_nocdb", cdb_data, 0);
    cyc();
    zero_in();

    // 3: fill FIFO while rejecting, 9th request collides with first pop
    for (int i = 0; i < 8; i++) begin
      set_req(0, 64'h100 + 64'(i * 8), 0, 7'(20 + i), 5'(i));
      cyc();
    end
    zero_in();
    at_neg();
    check("t3_full", req_ready, 0);
    cyc();
    set_req(0, 64'h999, 0, 1, 1);
    Dmem2proc_response = 1;
    at_neg();
    check("t3_full_pop", req_ready, 0);
    cyc();
    zero_in();
    at_neg();
    check("t3_ready_back", req_ready, 1);
    check("t3_next_head", proc2Dmem_addr, 64'h108);
    cyc();
    for (int i = 0; i < 7; i++) begin
      Dmem2proc_response = 4'(i + 2);
      cyc();
    end
    zero_in();
    at_neg();
    check("t3_no_ninth", proc2Dmem_command, 0);
    cyc();
    for (int i = 1; i <= 8; i++) begin
      Dmem2proc_tag = 4'(i); Dmem2proc_data = 64'(i * 3);
      at_neg();
      if (i == 3) begin
        check("t3_tag3_pr", cdb_pr, 22);
        check("t3_tag3_idx", fill_idx, 7'h22);
      end
      cyc();
    end
    zero_in();
    at_neg();
    check("t3_idle", idle, 1);
    cyc();

    // 4: pointer wrap, 20 requests streamed with immediate accept and return
    for (int c = 0; c < 23; c++) begin
      zero_in();
      if (c < 20) set_req(0, 64'h2000 + 64'(c * 8), 0, 7'(40 + c), 5'(c));
      if (c >= 1 && c <= 20) Dmem2proc_response = 4'(((c - 1) % 15) + 1);
      if (c >= 2 && c <= 21) begin
        Dmem2proc_tag = 4'(((c - 2) % 15) + 1); Dmem2proc_data = 64'(c);
      end
      at_neg();
      if (c >= 1 && c <= 20) check("t4_order", proc2Dmem_addr, 64'h2000 + 64'((c - 1) * 8));
      if (c == 7) check("t4_pr", cdb_pr, 45);
      cyc();
    end
    zero_in();
    at_neg();
    check("t4_idle", idle, 1);
    cyc();

    // 5: same-cycle fill and reallocation of tag 4
    set_req(0, 64'h3000, 0, 7, 1);
    cyc();
    zero_in();
    set_req(0, 64'h3400, 0, 12, 2);
    Dmem2proc_response = 4;
    cyc();
    zero_in();
    Dmem2proc_response = 4; Dmem2proc_tag = 4; Dmem2proc_data = 64'h11;
    at_neg();
    check("t5_old_pr", cdb_pr, 7);
    check("t5_old_tag", fill_tag, 22'hC);
    cyc();
    zero_in();
    at_neg();
    check("t5_popped", proc2Dmem_command, 0);
    check("t5_busy", idle, 0);
    cyc();
    Dmem2proc_tag = 4; Dmem2proc_data = 64'h22;
    at_neg();
    check("t5_new_pr", cdb_pr, 12);
    check("t5_new_tag", fill_tag, 22'hD);
    check("t5_new_data", cdb_data, 64'h22);
    cyc();
    zero_in();
    at_neg();
    check("t5_idle", idle, 1);
    cyc();

    // 6: reset with 3 queued and 2 outstanding
    set_req(0, 64'h500, 0, 3, 3);
    cyc();
    set_req(0, 64'h508, 0, 4, 4);
    Dmem2proc_response = 6;
    cyc();
    zero_in();
    set_req(1, 64'h600, 64'hA, 0, 0);
    Dmem2proc_response = 7;
    cyc();
    zero_in();
    set_req(0, 64'h608, 0, 5, 5);
    cyc();
    set_req(0, 64'h610, 0, 6, 6);
    cyc();
    zero_in();
    at_neg();
    check("t6_busy", idle, 0);
    check("t6_head", proc2Dmem_addr, 64'h600);
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    at_neg();
    check("t6_ready", req_ready, 1);
    check("t6_idle", idle, 1);
    check("t6_cmd", proc2Dmem_command, 0);
    check("t6_addr", proc2Dmem_addr, 0);
    cyc();
    Dmem2proc_tag = 6; Dmem2proc_data = 64'h66;
    at_neg();
    check("t6_tag6", fill_en, 0);
    cyc();
    Dmem2proc_tag = 7; Dmem2proc_data = 64'h67;
    at_neg();
    check("t6_tag7", cdb_load_en, 0);
    check("t6_tag7_pr", cdb_pr, 0);
    cyc();
    zero_in();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
